// File: rtl/c432_key_loader.sv
// c432_key_loader: receives the 35-bit c432 activation key serially and checks
// its even parity. Only a complete, checked key is presented to the locked
// core, through a holding register that is swapped in a single cycle.
module c432_key_loader #(
  parameter int KEY_P_W = 4,
  parameter int KEY_X_W = 31,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sin_valid,
  input  logic               sin_data,
  output logic               sin_ready,
  output logic [KEY_P_W-1:0] key_p,
  output logic [KEY_X_W-1:0] key_x,
  output logic               key_valid,
  output logic               load_err,
  output logic               busy
);

  // Frame = key bits followed by one parity bit.
  localparam int N     = KEY_P_W + KEY_X_W + 1;
  localparam int KEY_W = N - 1;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [15:0]      TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t             state;
  logic [KEY_W-1:0]   shadow;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        tcnt;
  logic               parity;

  // NOTE: sin_ready and busy are decoded from the state register alone, so they
  // never depend combinationally on sin_valid or start.
  assign sin_ready = (state == SHIFT);
  assign busy      = (state == SHIFT) || (state == CHECK);

  // Load sequencer: shifts key bits into the shadow register, tracks parity and
  // idle time, and commits or clears the holding register at the end of a load.
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      cnt       <= '0;
      tcnt      <= '0;
      parity    <= 1'b0;
      key_p     <= '0;
      key_x     <= '0;
      key_valid <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SHIFT;
            shadow   <= '0;
            cnt      <= '0;
            tcnt     <= '0;
            parity   <= 1'b0;
            load_err <= 1'b0;
          end
        end

        SHIFT: begin
          if (sin_valid) begin
            parity <= parity ^ sin_data;
            tcnt   <= '0;
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              // Parity bit: folded into the check, never stored for the core.
              state <= CHECK;
            end else begin
              // First bit received ends up in shadow[0] (p1).
              shadow <= {sin_data, shadow[KEY_W-1:1]};
            end
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TO_LAST) begin
              state <= ERROR;
            end
          end
        end

        CHECK: begin
          if (!parity) begin
            key_p     <= shadow[KEY_P_W-1:0];
            key_x     <= shadow[KEY_W-1:KEY_P_W];
            key_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            state <= ERROR;
          end
        end

        ERROR: begin
          load_err  <= 1'b1;
          key_valid <= 1'b0;
          key_p     <= '0;
          key_x     <= '0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
